// File: rtl/candy_vending_machine_moore_pkg.sv
// Shared definitions for the candy vending machine.
//   - state_t     : FSM state encoding (binary)
//   - COIN5_CODE  : coin code for a 5-unit coin
//   - COIN10_CODE : coin code for a 10-unit coin
//   - PRICE       : candy price in units
//   - CHANGE_AMT  : change returned on a 20-unit payment
package candy_vending_machine_moore_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        C5       = 3'd1,
        C10      = 3'd2,
        VEND     = 3'd3,
        VEND_CHG = 3'd4
    } state_t;

    localparam logic [3:0] COIN5_CODE  = 4'b0101;
    localparam logic [3:0] COIN10_CODE = 4'b1010;
    localparam logic [4:0] PRICE       = 5'd15;
    localparam logic [4:0] CHANGE_AMT  = 5'd5;

endpackage

// File: rtl/candy_vending_machine_moore_coin_decoder.sv
// Coin code decoder.
// Ports:
//   coin  in  [3:0] raw coin code from the acceptor
//   hit   out [1:0] one-hot {is5, is10}; 2'b00 for any unrecognised code
module candy_vending_machine_moore_coin_decoder
    import candy_vending_machine_moore_pkg::*;
(
    input  logic [3:0] coin,
    output logic [1:0] hit
);

    always_comb begin
        hit = 2'b00;
        if (coin == COIN5_CODE) begin
            hit = 2'b10;
        end else if (coin == COIN10_CODE) begin
            hit = 2'b01;
        end
    end

endmodule

// File: rtl/candy_vending_machine_moore.sv
// Moore FSM for a candy vending machine: 5- and 10-unit coins, price 15.
// One coin per clock; an overpay of 20 returns one 5-unit change.
// Ports:
//   clk      in       system clock, rising edge
//   rst      in       asynchronous active-high reset to IDLE
//   coin     in  [3:0] coin code sampled every rising edge
//   candy    out      one-cycle pulse while in a vend state
//   change   out      one-cycle pulse when 5 units of change are returned
//   balance  out [4:0] credit held (0/5/10) or amount paid in a vend state (15/20)
// Outputs depend on the state register only; coin never reaches an output
// combinationally.
module candy_vending_machine_moore
    import candy_vending_machine_moore_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] coin,
    output logic       candy,
    output logic       change,
    output logic [4:0] balance
);

    state_t     state;
    logic [1:0] hit;
    logic       is5;
    logic       is10;

    candy_vending_machine_moore_coin_decoder u_coin_decoder (
        .coin (coin),
        .hit  (hit)
    );

    assign is5  = hit[1];
    assign is10 = hit[0];

    // Vend states last one cycle; a coin arriving during a vend cycle is
    // credited to the next purchase, exactly as if the machine were idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, VEND, VEND_CHG: begin
                    if (is5)       state <= C5;
                    else if (is10) state <= C10;
                    else           state <= IDLE;
                end
                C5: begin
                    if (is5)       state <= C10;
                    else if (is10) state <= VEND;
                    else           state <= C5;
                end
                C10: begin
                    if (is5)       state <= VEND;
                    else if (is10) state <= VEND_CHG;
                    else           state <= C10;
                end
                // Unused encodings recover to IDLE on the next edge.
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode; unused encodings drive all outputs low.
    always_comb begin
        candy   = 1'b0;
        change  = 1'b0;
        balance = 5'd0;
        case (state)
            C5:       balance = 5'd5;
            C10:      balance = 5'd10;
            VEND: begin
                candy   = 1'b1;
                balance = PRICE;
            end
            VEND_CHG: begin
                candy   = 1'b1;
                change  = 1'b1;
                balance = PRICE + CHANGE_AMT;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_candy_vending_machine_moore.sv
// Directed self-checking bench for candy_vending_machine_moore.
// Outputs are compared as the packed word {candy, change, balance}.
module tb_candy_vending_machine_moore;

    logic       clk;
    logic       rst;
    logic [3:0] coin;
    logic       candy;
    logic       change;
    logic [4:0] balance;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] N0  = 4'b0000;
    localparam logic [3:0] K5  = 4'b0101;
    localparam logic [3:0] K10 = 4'b1010;

    candy_vending_machine_moore dut (
        .clk     (clk),
        .rst     (rst),
        .coin    (coin),
        .candy   (candy),
        .change  (change),
        .balance (balance)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (candy,change,balance)", tag, obs[6:0], exp[6:0]);
        end
    endtask

    task automatic check_out(input string tag, input logic e_candy, input logic e_change,
                             input logic [4:0] e_bal);
        check(tag, {1'b0, candy, change, balance}, {1'b0, e_candy, e_change, e_bal});
    endtask

    // Drive a coin code for one cycle (just after an edge) and check the
    // outputs 1 ns after the edge that samples it.
    task automatic step(input logic [3:0] c, input string tag, input logic e_candy,
                        input logic e_change, input logic [4:0] e_bal);
        coin = c;
        @(posedge clk);
        #1;
        check_out(tag, e_candy, e_change, e_bal);
    endtask

    initial begin
        // Reset held with a valid coin present: must stay IDLE.
        rst  = 1'b1;
        coin = K5;
        #1;
        check_out("reset_initial", 1'b0, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        check_out("reset_held_edge", 1'b0, 1'b0, 5'd0);
        rst  = 1'b0;
        coin = N0;
        @(posedge clk);
        #1;
        check_out("idle_after_reset", 1'b0, 1'b0, 5'd0);

        // 5 then 10 -> exact price
        step(K5,  "p5_10_a", 1'b0, 1'b0, 5'd5);
        step(K10, "p5_10_b", 1'b1, 1'b0, 5'd15);
        step(N0,  "p5_10_c", 1'b0, 1'b0, 5'd0);
        step(N0,  "p5_10_d", 1'b0, 1'b0, 5'd0);

        // 10 then 5
        step(K10, "p10_5_a", 1'b0, 1'b0, 5'd10);
        step(K5,  "p10_5_b", 1'b1, 1'b0, 5'd15);
        step(N0,  "p10_5_c", 1'b0, 1'b0, 5'd0);

        // 5, 5, 10 -> overpay with change (code held counts each cycle)
        step(K5,  "p5_5_10_a", 1'b0, 1'b0, 5'd5);
        step(K5,  "p5_5_10_b", 1'b0, 1'b0, 5'd10);
        step(K10, "p5_5_10_c", 1'b1, 1'b1, 5'd20);
        step(N0,  "p5_5_10_d", 1'b0, 1'b0, 5'd0);

        // 10, 10
        step(K10, "p10_10_a", 1'b0, 1'b0, 5'd10);
        step(K10, "p10_10_b", 1'b1, 1'b1, 5'd20);
        step(N0,  "p10_10_c", 1'b0, 1'b0, 5'd0);

        // Back-to-back: 10, 5, 5 -> vend, then new purchase at 5
        step(K10, "b2b_a", 1'b0, 1'b0, 5'd10);
        step(K5,  "b2b_b", 1'b1, 1'b0, 5'd15);
        step(K5,  "b2b_c", 1'b0, 1'b0, 5'd5);
        step(N0,  "b2b_hold", 1'b0, 1'b0, 5'd5);
        step(K10, "b2b_d", 1'b1, 1'b0, 5'd15);
        step(N0,  "b2b_e", 1'b0, 1'b0, 5'd0);

        // Coin 10 during VEND_CHG starts next purchase at C10
        step(K10, "chg_next_a", 1'b0, 1'b0, 5'd10);
        step(K10, "chg_next_b", 1'b1, 1'b1, 5'd20);
        step(K10, "chg_next_c", 1'b0, 1'b0, 5'd10);
        step(K5,  "chg_next_d", 1'b1, 1'b0, 5'd15);
        step(N0,  "chg_next_e", 1'b0, 1'b0, 5'd0);

        // Invalid codes in C5 are ignored; credit held without timeout
        step(K5,    "inv_a", 1'b0, 1'b0, 5'd5);
        step(4'hF,  "inv_1111", 1'b0, 1'b0, 5'd5);
        step(4'h3,  "inv_0011", 1'b0, 1'b0, 5'd5);
        for (int i = 0; i < 5; i++) begin
            step(N0, "inv_hold", 1'b0, 1'b0, 5'd5);
        end
        step(4'hA ^ 4'h1, "inv_1011", 1'b0, 1'b0, 5'd5);
        step(K5,  "inv_b", 1'b0, 1'b0, 5'd10);
        step(K5,  "inv_c", 1'b1, 1'b0, 5'd15);
        step(N0,  "inv_d", 1'b0, 1'b0, 5'd0);

        // Asynchronous reset mid-transaction in C10: clears between edges
        step(K10, "rst_mid_a", 1'b0, 1'b0, 5'd10);
        coin = K5;
        #2;
        rst = 1'b1;
        #1;
        check_out("rst_mid_async", 1'b0, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        check_out("rst_mid_edge", 1'b0, 1'b0, 5'd0);
        rst  = 1'b0;
        coin = N0;
        @(posedge clk);
        #1;
        check_out("rst_mid_no_vend", 1'b0, 1'b0, 5'd0);
        step(K5,  "rst_mid_fresh", 1'b0, 1'b0, 5'd5);
        step(N0,  "rst_mid_fresh_hold", 1'b0, 1'b0, 5'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
